memory_port_arbiter: RTL
========================

# memory_port_arbiter

Shares the single read/write port of the system memory between two requesters: the CPU (instruction fetch, load, store) and the I/O requester (display/peripheral reads and writes). Each cycle it grants at most one request, drives the memory port from that requester, and returns read data tagged to the owner after the memory read latency. It sits between the CPU's memory interface and the memory block, replacing the CPU's direct memory connection.

## Interface
- WIDTH, 16, data word width
- ADDRESS_WIDTH, 16, memory address width
- READ_LATENCY, 1, memory read latency in cycles (legal 1..4)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_request  in  1  CPU wants a transaction; held until granted
- cpu_write_enable  in  1  1 = write, 0 = read
- cpu_address  in  ADDRESS_WIDTH  transaction address
- cpu_write_data  in  WIDTH  write data
- cpu_grant  out  1  transaction issued this cycle
- cpu_read_valid  out  1  cpu_read_data valid this cycle
- cpu_read_data  out  WIDTH  returned read data
- io_request, io_write_enable, io_address, io_write_data, io_grant, io_read_valid, io_read_data: same as cpu_* for the I/O requester
- memory_write_enable  out  1  memory port write strobe
- memory_address  out  ADDRESS_WIDTH  memory port address
- memory_write_data  out  WIDTH  memory port write data
- memory_read_data  in  WIDTH  memory port read data, valid READ_LATENCY cycles after address

## Operation
- Arbitration is combinational from the requests and a registered round-robin pointer `last_owner` (CPU or IO).
- Only one requests: it is granted.
- Both request: the owner that is not `last_owner` is granted.
- Neither requests: no grant; memory_write_enable=0, memory_address=0, memory_write_data=0.
- On a grant, the memory port is driven combinationally from the granted requester's address/write_enable/write_data in the same cycle. `last_owner` updates at the clock edge.
- A requester keeps request, address, write_enable and write_data stable until it sees grant. Deasserting request before grant is legal and cancels the transaction.
- Reads: a tag {valid, owner} enters a READ_LATENCY-deep shift register at the grant. When it exits, the owner's read_valid is asserted for 1 cycle and its read_data = memory_read_data.
- Writes create no tag and produce no read_valid.
- Both read_data outputs always carry memory_read_data; only read_valid is steered.
- A single persistent requester is granted every cycle, with back-to-back reads pipelined and no bubbles.
- Under contention, grants alternate strictly, so the maximum wait is 1 cycle.

## Timing
- Grant latency: 0 cycles, same cycle as request when the port is available.
- Read latency: read_valid exactly READ_LATENCY cycles after the granting cycle.
- Reset values: last_owner=IO (so the first contended grant goes to the CPU), tag pipeline cleared, all grant/read_valid outputs 0, memory_write_enable=0.
- Reset mid-operation: in-flight read tags are discarded, so no read_valid appears after reset for reads issued before it. Grants are forced to 0 while reset is high.
- At most one of cpu_grant/io_grant is high, and at most one of cpu_read_valid/io_read_valid is high, in any cycle.
- Requests and grants in the same cycle as a returning read_valid are independent; the pipeline accepts a new tag every cycle.

## Structure
- Shared package: OWNER_CPU=1'b0 and OWNER_IO=1'b1 owner encodings, plus the tag struct {valid, owner}.
- Sub-module read_tag_pipeline: a parameterized READ_LATENCY-deep shift register of tags with synchronous reset.
- The top level holds the arbitration logic, the last_owner register and the port muxing.

## Test plan
- Reset, then cpu read @0x0010 alone with memory word 0x1234, READ_LATENCY=1 -> cpu_grant same cycle, cpu_read_valid with 0x1234 next cycle, io_read_valid stays 0.
- Both request reads continuously for 6 cycles -> grants alternate CPU, IO, CPU, IO, CPU, IO; each owner's read_valid follows its own grant by READ_LATENCY.
- io write 0xBEEF @0x0200 while cpu idle -> io_grant, memory_write_enable=1 for 1 cycle, no read_valid; a later cpu read @0x0200 returns 0xBEEF.
- READ_LATENCY=3, cpu back-to-back reads @0x0..0x3 -> 4 consecutive cpu_read_valid pulses starting 3 cycles after the first grant, in address order.
- Reset asserted 1 cycle after an io read grant -> io_read_valid never asserts, and after reset the first contended request goes to the CPU.
- cpu_request dropped before grant during IO contention -> no cpu transaction issued, and memory_address never shows the cpu address.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared owner encodings and read tag type
// Purpose: types shared by the arbiter top level and its read tag pipeline.
//   OWNER_CPU / OWNER_IO : one-bit owner encodings
//   read_tag_t           : {valid, owner} tag carried alongside an issued read
package memory_port_arbiter_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_IO  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } read_tag_t;

endpackage

// File: rtl/read_tag_pipeline.sv
// rtl/read_tag_pipeline.sv - fixed-depth shift register of read tags
// Purpose: delays each issued read tag by DEPTH cycles so it lines up with
// the memory's returned read data.
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset, clears every stage
//   tag_in  in   tag captured this cycle (valid=0 when no read is issued)
//   tag_out out  tag captured DEPTH cycles ago
module read_tag_pipeline
  import memory_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  read_tag_t tag_in,
  output read_tag_t tag_out
);

  read_tag_t stages [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - two-requester round-robin memory port arbiter
// Purpose: shares one memory read/write port between the CPU and the I/O
// requester, granting at most one transaction per cycle and steering the
// returned read data's valid strobe back to the owner of each read.
//   clock, reset                      rising-edge clock, sync active-high reset
//   cpu_request/write_enable/address/write_data   CPU transaction request
//   cpu_grant, cpu_read_valid, cpu_read_data      CPU grant and read return
//   io_*                                          same set for the I/O requester
//   memory_write_enable/address/write_data        memory port drive
//   memory_read_data                              memory data, READ_LATENCY late
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_request,
  input  logic                     cpu_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [WIDTH-1:0]         cpu_write_data,
  output logic                     cpu_grant,
  output logic                     cpu_read_valid,
  output logic [WIDTH-1:0]         cpu_read_data,
  input  logic                     io_request,
  input  logic                     io_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] io_address,
  input  logic [WIDTH-1:0]         io_write_data,
  output logic                     io_grant,
  output logic                     io_read_valid,
  output logic [WIDTH-1:0]         io_read_data,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [WIDTH-1:0]         memory_write_data,
  input  logic [WIDTH-1:0]         memory_read_data
);

  logic      last_owner;
  read_tag_t tag_in;
  read_tag_t tag_out;

  // Contention goes to whichever side did not win last time.
  always_comb begin
    cpu_grant = 1'b0;
    io_grant  = 1'b0;
    if (!reset) begin
      if (cpu_request && io_request) begin
        if (last_owner == OWNER_IO) cpu_grant = 1'b1;
        else                        io_grant  = 1'b1;
      end else if (cpu_request) begin
        cpu_grant = 1'b1;
      end else if (io_request) begin
        io_grant = 1'b1;
      end
    end
  end

  always_comb begin
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    if (cpu_grant) begin
      memory_write_enable = cpu_write_enable;
      memory_address      = cpu_address;
      memory_write_data   = cpu_write_data;
    end else if (io_grant) begin
      memory_write_enable = io_write_enable;
      memory_address      = io_address;
      memory_write_data   = io_write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= OWNER_IO;
    end else if (cpu_grant) begin
      last_owner <= OWNER_CPU;
    end else if (io_grant) begin
      last_owner <= OWNER_IO;
    end
  end

  // Only granted reads produce a tag; writes leave valid low.
  always_comb begin
    tag_in.valid = (cpu_grant && !cpu_write_enable) || (io_grant && !io_write_enable);
    tag_in.owner = io_grant ? OWNER_IO : OWNER_CPU;
  end

  read_tag_pipeline #(
    .DEPTH(READ_LATENCY)
  ) u_read_tag_pipeline (
    .clock  (clock),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // The last stage still holds a pre-reset tag during the reset cycle itself,
  // so the valid strobes are masked while reset is high.
  assign cpu_read_valid = !reset && tag_out.valid && (tag_out.owner == OWNER_CPU);
  assign io_read_valid  = !reset && tag_out.valid && (tag_out.owner == OWNER_IO);
  assign cpu_read_data  = memory_read_data;
  assign io_read_data   = memory_read_data;

endmodule
